// File: rtl/mvp_ahb2apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one AHB single transfer becomes one APB SETUP/ACCESS pair.
// APB slave errors, bad transfer sizes and PREADY timeouts are returned as a two-cycle AHB ERROR.
module mvp_ahb2apb_bridge #(
  parameter int          AW     = 32,
  parameter int          DW     = 32,
  parameter int unsigned TO_CYC = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_si_hsel,
  input  logic [1:0]    i_si_htrans,
  input  logic          i_si_hwrite,
  input  logic [2:0]    i_si_hsize,
  input  logic [AW-1:0] i_si_haddr,
  input  logic [DW-1:0] i_si_hwdata,
  input  logic          i_si_hready,
  output logic [DW-1:0] o_si_hrdata,
  output logic          o_si_hreadyout,
  output logic          o_si_hresp,
  output logic          o_mi_psel,
  output logic          o_mi_penable,
  output logic          o_mi_pwrite,
  output logic [AW-1:0] o_mi_paddr,
  output logic [DW-1:0] o_mi_pwdata,
  input  logic [DW-1:0] i_mi_prdata,
  input  logic          i_mi_pready,
  input  logic          i_mi_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE, S_WDAT, S_SETUP, S_ACCESS, S_ERR1, S_ERR2
  } state_e;

  localparam logic [31:0] TO_LIM = 32'(TO_CYC);

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          accept;
  logic          accept_pt;
  logic          unused_htrans0;

  // htrans[0] only separates SEQ from NONSEQ, which a single-transfer bridge treats alike
  assign unused_htrans0 = i_si_htrans[0];
  assign accept         = i_si_hsel & i_si_htrans[1] & i_si_hready;
  assign accept_pt      = (state_q == S_IDLE) || (state_q == S_ERR2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_ERR2: begin
        if (!accept)                   state_d = S_IDLE;
        else if (i_si_hsize != 3'b010) state_d = S_ERR1;
        else if (i_si_hwrite)          state_d = S_WDAT;
        else                           state_d = S_SETUP;
      end
      S_WDAT:  state_d = S_SETUP;
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (i_mi_pready) begin
          cnt_d   = '0;
          state_d = i_mi_pslverr ? S_ERR1 : S_IDLE;
        end else if ((TO_LIM != 32'd0) && ((cnt_q + 32'd1) >= TO_LIM)) begin
          cnt_d   = '0;
          state_d = S_ERR1;
        end else begin
          cnt_d   = cnt_q + 32'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered images of the next state so they line up with state_q
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      o_mi_psel      <= 1'b0;
      o_mi_penable   <= 1'b0;
      o_mi_pwrite    <= 1'b0;
      o_mi_paddr     <= '0;
      o_mi_pwdata    <= '0;
      o_si_hrdata    <= '0;
      o_si_hreadyout <= 1'b1;
      o_si_hresp     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      o_mi_psel      <= (state_d == S_SETUP) || (state_d == S_ACCESS);
      o_mi_penable   <= (state_d == S_ACCESS);
      o_si_hreadyout <= (state_d == S_IDLE) || (state_d == S_ERR2);
      o_si_hresp     <= (state_d == S_ERR1) || (state_d == S_ERR2);
      if (accept_pt && accept) begin
        o_mi_paddr  <= i_si_haddr;
        o_mi_pwrite <= i_si_hwrite;
      end
      if (state_q == S_WDAT) begin
        o_mi_pwdata <= i_si_hwdata;
      end
      if ((state_q == S_ACCESS) && i_mi_pready && !i_mi_pslverr && !o_mi_pwrite) begin
        o_si_hrdata <= i_mi_prdata;
      end
    end
  end

endmodule

// File: tb/tb_mvp_ahb2apb_bridge.sv
// Bench for mvp_ahb2apb_bridge: directed cases then random transfers checked against a
// per-transfer cycle timeline derived from the bridge's protocol rules.
module tb_mvp_ahb2apb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel, hwrite, hready, hreadyout, hresp;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata, hrdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  logic        hsel_0, hwrite_0, hready_0, hreadyout_0, hresp_0;
  logic [1:0]  htrans_0;
  logic [2:0]  hsize_0;
  logic [31:0] haddr_0, hwdata_0, hrdata_0;
  logic        psel_0, penable_0, pwrite_0, pready_0, pslverr_0;
  logic [31:0] paddr_0, pwdata_0, prdata_0;

  always #5 clk = ~clk;

  mvp_ahb2apb_bridge #(.AW(32), .DW(32), .TO_CYC(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_si_hsel(hsel), .i_si_htrans(htrans), .i_si_hwrite(hwrite), .i_si_hsize(hsize),
    .i_si_haddr(haddr), .i_si_hwdata(hwdata), .i_si_hready(hready),
    .o_si_hrdata(hrdata), .o_si_hreadyout(hreadyout), .o_si_hresp(hresp),
    .o_mi_psel(psel), .o_mi_penable(penable), .o_mi_pwrite(pwrite),
    .o_mi_paddr(paddr), .o_mi_pwdata(pwdata),
    .i_mi_prdata(prdata), .i_mi_pready(pready), .i_mi_pslverr(pslverr)
  );

  mvp_ahb2apb_bridge #(.AW(32), .DW(32), .TO_CYC(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_si_hsel(hsel_0), .i_si_htrans(htrans_0), .i_si_hwrite(hwrite_0), .i_si_hsize(hsize_0),
    .i_si_haddr(haddr_0), .i_si_hwdata(hwdata_0), .i_si_hready(hready_0),
    .o_si_hrdata(hrdata_0), .o_si_hreadyout(hreadyout_0), .o_si_hresp(hresp_0),
    .o_mi_psel(psel_0), .o_mi_penable(penable_0), .o_mi_pwrite(pwrite_0),
    .o_mi_paddr(paddr_0), .o_mi_pwdata(pwdata_0),
    .i_mi_prdata(prdata_0), .i_mi_pready(pready_0), .i_mi_pslverr(pslverr_0)
  );

  typedef struct packed {
    logic psel, pen, rdy, resp, last, fin;
  } cyc_t;

  localparam int TO = 4;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_rd = 32'h0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input logic ps, pe, rd, rs, la, fi);
    cyc_t c;
    c.psel = ps; c.pen = pe; c.rdy = rd; c.resp = rs; c.last = la; c.fin = fi;
    return c;
  endfunction

  // Drives one AHB transfer starting in the current (accepting) cycle and checks every
  // following cycle against the expected timeline; returns the HREADYOUT-low and
  // PENABLE-high cycle counts.
  task automatic xfer(input string nm, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [2:0] size, input int waits,
                      input logic err, input logic [31:0] rdat,
                      output int lows, output int pens);
    cyc_t tl[$];
    cyc_t c;
    logic tmo;
    int   nacc;
    if (size != 3'b010) begin
      tl.push_back(mk(0, 0, 0, 1, 0, 0));
      tl.push_back(mk(0, 0, 1, 1, 0, 0));
    end else begin
      if (wr) tl.push_back(mk(0, 0, 0, 0, 0, 0));
      tl.push_back(mk(1, 0, 0, 0, 0, 0));
      tmo  = (waits >= TO);
      nacc = tmo ? TO : waits + 1;
      for (int j = 0; j < nacc; j++) tl.push_back(mk(1, 1, 0, 0, !tmo && (j == waits), 0));
      if (tmo || err) begin
        tl.push_back(mk(0, 0, 0, 1, 0, 0));
        tl.push_back(mk(0, 0, 1, 1, 0, 0));
      end else begin
        tl.push_back(mk(0, 0, 1, 0, 0, !wr));
      end
    end
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = size; haddr = addr; hready = 1'b1;
    @(posedge clk); #1;
    hsel = 1'($urandom); htrans = 2'b00; hwrite = 1'($urandom); haddr = $urandom;
    hsize = 3'($urandom); hwdata = data;
    lows = 0; pens = 0;
    foreach (tl[k]) begin
      if (k > 0) begin @(posedge clk); #1; end
      c = tl[k];
      if (k == 1) hwdata = $urandom;
      chk1($sformatf("%s c%0d psel", nm, k), psel, c.psel);
      chk1($sformatf("%s c%0d penable", nm, k), penable, c.pen);
      chk1($sformatf("%s c%0d hreadyout", nm, k), hreadyout, c.rdy);
      chk1($sformatf("%s c%0d hresp", nm, k), hresp, c.resp);
      if (c.psel) begin
        chk32($sformatf("%s c%0d paddr", nm, k), paddr, addr);
        chk1($sformatf("%s c%0d pwrite", nm, k), pwrite, wr);
        if (wr) chk32($sformatf("%s c%0d pwdata", nm, k), pwdata, data);
      end
      if (c.fin) exp_rd = rdat;
      chk32($sformatf("%s c%0d hrdata", nm, k), hrdata, exp_rd);
      lows += (hreadyout == 1'b0) ? 1 : 0;
      pens += (penable == 1'b1) ? 1 : 0;
      pready  = c.last;
      pslverr = c.last & err;
      prdata  = c.last ? rdat : $urandom;
    end
    pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 3))
        0:       begin hsel = 1'b0; htrans = 2'b10; hready = 1'b1; end
        1:       begin hsel = 1'b1; htrans = 2'b01; hready = 1'b1; end
        2:       begin hsel = 1'b1; htrans = 2'b10; hready = 1'b0; end
        default: begin hsel = 1'b1; htrans = 2'b00; hready = 1'b1; end
      endcase
      hsize = 3'($urandom); hwrite = 1'($urandom); haddr = $urandom;
      @(posedge clk); #1;
      chk1("idle hreadyout", hreadyout, 1'b1);
      chk1("idle hresp", hresp, 1'b0);
      chk1("idle psel", psel, 1'b0);
      chk32("idle hrdata", hrdata, exp_rd);
    end
    hsel = 1'b0; htrans = 2'b00; hready = 1'b1;
  endtask

  initial begin
    int          lows, pens;
    logic        wr, err;
    logic [31:0] addr;
    logic [2:0]  size;

    rst = 1'b1;
    hsel = 0; htrans = 0; hwrite = 0; hsize = 3'b010; haddr = 0; hwdata = 0; hready = 1;
    prdata = 0; pready = 0; pslverr = 0;
    hsel_0 = 0; htrans_0 = 0; hwrite_0 = 0; hsize_0 = 3'b010; haddr_0 = 0; hwdata_0 = 0;
    hready_0 = 1; prdata_0 = 0; pready_0 = 0; pslverr_0 = 0;
    #1;
    chk1("rst psel", psel, 1'b0);
    chk1("rst penable", penable, 1'b0);
    chk1("rst pwrite", pwrite, 1'b0);
    chk32("rst paddr", paddr, 32'h0);
    chk32("rst pwdata", pwdata, 32'h0);
    chk32("rst hrdata", hrdata, 32'h0);
    chk1("rst hreadyout", hreadyout, 1'b1);
    chk1("rst hresp", hresp, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // T1: read, zero wait
    xfer("T1", 1'b0, 32'h5500_0010, 32'h0, 3'b010, 0, 1'b0, 32'hA5A5_0001, lows, pens);
    chk32("T1 low cycles", 32'(lows), 32'd2);
    chk32("T1 hrdata", hrdata, 32'hA5A5_0001);
    idle(1);

    // T2: write, two PREADY waits
    xfer("T2", 1'b1, 32'h5600_0004, 32'h1234_5678, 3'b010, 2, 1'b0, 32'h0, lows, pens);
    chk32("T2 low cycles", 32'(lows), 32'd5);
    chk32("T2 penable cycles", 32'(pens), 32'd3);
    chk32("T2 hrdata kept", hrdata, 32'hA5A5_0001);

    // T3: slave error, then back-to-back read accepted in ERR2
    xfer("T3a", 1'b0, 32'h5500_0020, 32'h0, 3'b010, 1, 1'b1, 32'hDEAD_BEEF, lows, pens);
    xfer("T3b", 1'b0, 32'h5600_0008, 32'h0, 3'b010, 0, 1'b0, 32'h0BAD_F00D, lows, pens);
    chk32("T3 hrdata", hrdata, 32'h0BAD_F00D);

    // T4: halfword write rejected without APB access
    xfer("T4", 1'b1, 32'h5500_0030, 32'hCAFE_0000, 3'b001, 0, 1'b0, 32'h0, lows, pens);
    chk32("T4 penable cycles", 32'(pens), 32'd0);
    chk32("T4 low cycles", 32'(lows), 32'd1);
    idle(1);

    // T5a: timeout after TO access cycles
    xfer("T5a", 1'b0, 32'h5600_0040, 32'h0, 3'b010, 10, 1'b0, 32'h1111_2222, lows, pens);
    chk32("T5a penable cycles", 32'(pens), 32'(TO));
    idle(1);

    // T5b: timeout disabled, bridge waits for PREADY
    hsel_0 = 1'b1; htrans_0 = 2'b10; hwrite_0 = 1'b0; haddr_0 = 32'h5500_0044;
    @(posedge clk); #1;
    hsel_0 = 1'b0; htrans_0 = 2'b00;
    chk1("T5b setup psel", psel_0, 1'b1);
    chk1("T5b setup penable", penable_0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk1($sformatf("T5b wait%0d penable", i), penable_0, 1'b1);
      chk1($sformatf("T5b wait%0d hreadyout", i), hreadyout_0, 1'b0);
      chk1($sformatf("T5b wait%0d hresp", i), hresp_0, 1'b0);
    end
    pready_0 = 1'b1; prdata_0 = 32'h7777_0005;
    @(posedge clk); #1;
    pready_0 = 1'b0;
    chk1("T5b done psel", psel_0, 1'b0);
    chk1("T5b done hreadyout", hreadyout_0, 1'b1);
    chk1("T5b done hresp", hresp_0, 1'b0);
    chk32("T5b done hrdata", hrdata_0, 32'h7777_0005);

    // T6: asynchronous reset in ACCESS
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hsize = 3'b010; haddr = 32'h5500_0050;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    chk1("T6 in access", penable, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("T6 psel", psel, 1'b0);
    chk1("T6 penable", penable, 1'b0);
    chk1("T6 hreadyout", hreadyout, 1'b1);
    chk1("T6 hresp", hresp, 1'b0);
    chk32("T6 hrdata", hrdata, 32'h0);
    exp_rd = 32'h0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    xfer("T6r", 1'b0, 32'h5600_0060, 32'h0, 3'b010, 1, 1'b0, 32'h6666_0006, lows, pens);

    // Random transfers with ignored-bus gaps
    for (int t = 0; t < 40; t++) begin
      wr   = 1'($urandom);
      addr = ($urandom_range(0, 1) != 0 ? 32'h5500_0000 : 32'h5600_0000) |
             (32'($urandom_range(0, 65535)) & 32'h0000_FFFC);
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      err  = ($urandom_range(0, 3) == 0);
      xfer($sformatf("R%0d", t), wr, addr, $urandom, size, $urandom_range(0, 5), err,
           $urandom, lows, pens);
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
